// File: rtl/frv_dmem_arbiter.sv
// Two-port data-memory bus arbiter with grant lock and response-routing ID FIFO.
// Define FRV_DMEM_ARB_RR_EN for round-robin; otherwise port 0 has fixed priority.
module frv_dmem_arbiter #(
  parameter int XLEN        = 32,
  parameter int OUTSTANDING = 2
) (
  input  logic                             g_clk,
  input  logic                             g_resetn,
  input  logic                             p0_req,
  input  logic                             p0_wen,
  input  logic [3:0]                       p0_strb,
  input  logic [XLEN-1:0]                  p0_wdata,
  input  logic [XLEN-1:0]                  p0_addr,
  output logic                             p0_gnt,
  output logic                             p0_recv,
  input  logic                             p0_ack,
  output logic [XLEN-1:0]                  p0_rdata,
  output logic                             p0_error,
  input  logic                             p1_req,
  input  logic                             p1_wen,
  input  logic [3:0]                       p1_strb,
  input  logic [XLEN-1:0]                  p1_wdata,
  input  logic [XLEN-1:0]                  p1_addr,
  output logic                             p1_gnt,
  output logic                             p1_recv,
  input  logic                             p1_ack,
  output logic [XLEN-1:0]                  p1_rdata,
  output logic                             p1_error,
  output logic                             m_req,
  output logic                             m_wen,
  output logic [3:0]                       m_strb,
  output logic [XLEN-1:0]                  m_wdata,
  output logic [XLEN-1:0]                  m_addr,
  input  logic                             m_gnt,
  input  logic                             m_recv,
  input  logic                             m_error,
  input  logic [XLEN-1:0]                  m_rdata,
  output logic                             m_ack,
  output logic [$clog2(OUTSTANDING+1)-1:0] arb_pending,
  output logic                             arb_rsp_err
);

  localparam int CW = $clog2(OUTSTANDING + 1);
  localparam int PW = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic { UNLOCKED, LOCKED } lock_t;

  lock_t                  lock_q;
  logic                   lock_id;
  logic                   win;
  logic                   sel;
  logic                   hs;
  logic                   pop;
  logic                   full;
  logic                   empty;
  logic                   head;
  logic [OUTSTANDING-1:0] fifo_id;
  logic [PW-1:0]          rd_ptr;
  logic [PW-1:0]          wr_ptr;
  logic [CW-1:0]          count;

  function automatic logic [PW-1:0] ptr_nxt(input logic [PW-1:0] p);
    return (p == PW'(OUTSTANDING - 1)) ? '0 : p + PW'(1);
  endfunction

`ifdef FRV_DMEM_ARB_RR_EN
  logic rr_ptr;

  always_comb begin
    win = 1'b0;
    if (p0_req && p1_req) win = rr_ptr;
    else                  win = p1_req;
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn)  rr_ptr <= 1'b0;
    else if (hs)    rr_ptr <= ~sel;
  end
`else
  always_comb begin
    win = !p0_req && p1_req;
  end
`endif

  assign sel   = (lock_q == LOCKED) ? lock_id : win;
  assign full  = (count == CW'(OUTSTANDING));
  assign empty = (count == '0);
  assign head  = fifo_id[rd_ptr];

  assign m_req   = (sel ? p1_req : p0_req) && !full;
  assign m_wen   = sel ? p1_wen   : p0_wen;
  assign m_strb  = sel ? p1_strb  : p0_strb;
  assign m_wdata = sel ? p1_wdata : p0_wdata;
  assign m_addr  = sel ? p1_addr  : p0_addr;

  assign hs     = m_req && m_gnt;
  assign p0_gnt = hs && !sel;
  assign p1_gnt = hs &&  sel;

  // An empty FIFO drains stray responses by acking them unconditionally.
  assign m_ack    = empty ? m_recv : (head ? p1_ack : p0_ack);
  assign pop      = m_recv && m_ack && !empty;
  assign p0_recv  = m_recv && !empty && !head;
  assign p1_recv  = m_recv && !empty &&  head;
  assign p0_rdata = m_rdata;
  assign p1_rdata = m_rdata;
  assign p0_error = m_error;
  assign p1_error = m_error;

  assign arb_pending = count;

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      lock_q  <= UNLOCKED;
      lock_id <= 1'b0;
    end else begin
      unique case (lock_q)
        UNLOCKED: if (m_req && !m_gnt) begin
          lock_q  <= LOCKED;
          lock_id <= sel;
        end
        LOCKED: if (hs) lock_q <= UNLOCKED;
        default: lock_q <= UNLOCKED;
      endcase
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      fifo_id     <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      arb_rsp_err <= 1'b0;
    end else begin
      if (hs) begin
        fifo_id[wr_ptr] <= sel;
        wr_ptr          <= ptr_nxt(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_nxt(rd_ptr);
      if (hs && !pop)      count <= count + CW'(1);
      else if (!hs && pop) count <= count - CW'(1);
      if (m_recv && empty) arb_rsp_err <= 1'b1;
    end
  end

endmodule
